// File: rtl/multiplex_display_n.sv
// -----------------------------------------------------------------------------
// multiplex_display_n
//
// Time-multiplexed driver for NUM_DIGITS common-select 7-segment hex digits.
// Each digit owns a slot of REFRESH_CNT clocks. The first GAP_CNT clocks of
// every slot are dead time (all enables low) to stop ghosting between digits.
// Digit values are double-buffered: a load writes a pending buffer, and the
// pending buffer is copied to the displayed (active) buffer only at a frame
// boundary, so a frame never shows a mix of old and new values. Optional
// leading-zero blanking suppresses segments of zero digits above the highest
// non-zero digit (digit 0 is never blanked; decimal points are unaffected).
//
// Optional build feature (macro MUXDISP_BLINK_EN):
//   Adds parameter BLINK_FRAMES and input blink_mask. A blink phase bit toggles
//   every BLINK_FRAMES frames; while the phase is off, enables of digits whose
//   active blink_mask bit is set are held low. Without the macro there is no
//   blink port or state.
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   digits_in        4*NUM_DIGITS hex digits, digit i at [4i+3:4i]
//   load             1-cycle strobe, captures digits_in/dp_in into pending
//   dp_in            per-digit decimal-point request
//   blink_mask       (MUXDISP_BLINK_EN only) per-digit blink request
//   blank_lz         leading-zero blanking enable, level
//   segments         {g,f,e,d,c,b,a}, active-high, registered
//   dp_out           decimal point of current digit, registered
//   enable_displays  one-hot digit select, registered
//   scan_idx         current slot index (live state, not an output register)
//   frame_done       1-cycle pulse in the first cycle after the scan wraps to 0
// -----------------------------------------------------------------------------
module multiplex_display_n #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_CNT = 50000,
  parameter int GAP_CNT     = 500
`ifdef MUXDISP_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic                          load,
  input  logic [NUM_DIGITS-1:0]         dp_in,
`ifdef MUXDISP_BLINK_EN
  input  logic [NUM_DIGITS-1:0]         blink_mask,
`endif
  input  logic                          blank_lz,
  output logic [6:0]                    segments,
  output logic                          dp_out,
  output logic [NUM_DIGITS-1:0]         enable_displays,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_done
);

  localparam int CNT_W = $clog2(REFRESH_CNT);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Hex to {g,f,e,d,c,b,a}; lower-case b and d keep them distinct from 8 and 0.
  function automatic logic [6:0] seg_decode(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1101111;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b1111100;
      4'hC:    seg = 7'b0111001;
      4'hD:    seg = 7'b1011110;
      4'hE:    seg = 7'b1111001;
      default: seg = 7'b1110001;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
  logic                    pend_valid;

  logic                    slot_end;
  logic                    frame_end;
  logic                    in_gap;
  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    upper_zero;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [NUM_DIGITS-1:0]   blink_hide;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);
  assign scan_idx  = idx_q;

  // With no dead time the comparison would be against zero and always false.
  generate
    if (GAP_CNT == 0) begin : g_no_gap
      assign in_gap = 1'b0;
    end else begin : g_gap
      assign in_gap = (cnt_q < CNT_W'(GAP_CNT));
    end
  endgenerate

  // Refresh counter and slot index.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (slot_end) begin
      cnt_q <= '0;
      // Explicit wrap: NUM_DIGITS need not be a power of two.
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Double buffer. A load in the boundary cycle only refreshes pending and
  // keeps pending_valid set, so it is shown one frame later.
  // NOTE: both buffers are small flop banks, not RAM, so they take the async
  // reset; a reset must not leave stale digits on the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_valid  <= 1'b0;
      act_digits  <= '0;
      act_dp      <= '0;
    end else begin
      if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
      end
      if (frame_end && pend_valid) begin
        act_digits <= pend_digits;
        act_dp     <= pend_dp;
      end
      if (load) begin
        pend_valid <= 1'b1;
      end else if (frame_end) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // Select the current digit and decide leading-zero blanking. Walking from
  // the top digit down, upper_zero tells whether digits i..NUM_DIGITS-1 are
  // all zero at the moment digit i is visited.
  // NOTE: every signal gets a default before the loop so no path through this
  // block leaves a value held, which would infer a latch.
  always_comb begin
    cur_digit  = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (act_digits[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        cur_digit = act_digits[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_blank = blank_lz && (i != 0) && upper_zero;
      end
    end
  end

  always_comb begin
    onehot        = '0;
    onehot[idx_q] = 1'b1;
  end

`ifdef MUXDISP_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

  logic [NUM_DIGITS-1:0] pend_blink, act_blink;
  logic [BF_W-1:0]       bf_cnt;
  logic                  blink_on;

  // Blink mask travels through the same double buffer as the digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_blink <= '0;
      act_blink  <= '0;
    end else begin
      if (load) begin
        pend_blink <= blink_mask;
      end
      if (frame_end && pend_valid) begin
        act_blink <= pend_blink;
      end
    end
  end

  // Phase starts on and flips after every BLINK_FRAMES frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bf_cnt   <= '0;
      blink_on <= 1'b1;
    end else if (frame_end) begin
      if (bf_cnt == BF_LAST) begin
        bf_cnt   <= '0;
        blink_on <= ~blink_on;
      end else begin
        bf_cnt <= bf_cnt + BF_W'(1);
      end
    end
  end

  assign blink_hide = blink_on ? '0 : act_blink;
`else
  assign blink_hide = '0;
`endif

  // Output registers: cycle n+1 shows what counter/index/buffer held in cycle n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments        <= '0;
      dp_out          <= 1'b0;
      enable_displays <= '0;
      frame_done      <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (in_gap) begin
        segments        <= '0;
        dp_out          <= 1'b0;
        enable_displays <= '0;
      end else begin
        segments        <= cur_blank ? 7'd0 : seg_decode(cur_digit);
        dp_out          <= cur_dp;
        enable_displays <= onehot & ~blink_hide;
      end
    end
  end

endmodule

// File: tb/tb_multiplex_display_n.sv
// -----------------------------------------------------------------------------
// tb_multiplex_display_n
//
// Bench for multiplex_display_n with NUM_DIGITS=4, REFRESH_CNT=20, GAP_CNT=2.
// The reference model is purely time-indexed: after reset release, cycle k
// belongs to slot (k/R)%N at offset k%R, and the digits shown in frame f are
// those of the newest load made no later than two cycles before the frame
// starts. Outputs are compared against the model every cycle on the falling
// edge; directed checks with hand-computed values pin the model itself, then
// randomized loads / blanking run against the model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multiplex_display_n;

  localparam int N  = 4;
  localparam int R  = 20;
  localparam int G  = 2;
  localparam int NR = N * R;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [4*N-1:0]       digits_in = '0;
  logic                 load = 1'b0;
  logic [N-1:0]         dp_in = '0;
  logic                 blank_lz = 1'b0;
  logic [6:0]           segments;
  logic                 dp_out;
  logic [N-1:0]         enable_displays;
  logic [$clog2(N)-1:0] scan_idx;
  logic                 frame_done;
`ifdef MUXDISP_BLINK_EN
  logic [N-1:0]         blink_mask = '0;
`endif

  multiplex_display_n #(
    .NUM_DIGITS (N),
    .REFRESH_CNT(R),
    .GAP_CNT    (G)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .digits_in      (digits_in),
    .load           (load),
    .dp_in          (dp_in),
`ifdef MUXDISP_BLINK_EN
    .blink_mask     (blink_mask),
`endif
    .blank_lz       (blank_lz),
    .segments       (segments),
    .dp_out         (dp_out),
    .enable_displays(enable_displays),
    .scan_idx       (scan_idx),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  typedef struct {
    int             cyc;
    logic [4*N-1:0] d;
    logic [N-1:0]   dp;
  } load_t;

  load_t loads[$];

  logic [6:0] seg_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  int                   k = 0;     // cycles elapsed since reset release
  logic [6:0]           exp_seg  = '0;
  logic                 exp_dp   = 1'b0;
  logic [N-1:0]         exp_en   = '0;
  logic                 exp_fd   = 1'b0;
  logic [$clog2(N)-1:0] exp_scan = '0;
  logic                 chk_en   = 1'b0;

  // Newest load made at least two cycles before the frame containing cyc began.
  function automatic logic [4*N-1:0] act_digits(input int cyc);
    int f0;
    logic [4*N-1:0] d;
    f0 = (cyc / NR) * NR;
    d  = '0;
    foreach (loads[i]) if (loads[i].cyc <= f0 - 2) d = loads[i].d;
    return d;
  endfunction

  function automatic logic [N-1:0] act_dps(input int cyc);
    int f0;
    logic [N-1:0] p;
    f0 = (cyc / NR) * NR;
    p  = '0;
    foreach (loads[i]) if (loads[i].cyc <= f0 - 2) p = loads[i].dp;
    return p;
  endfunction

  function automatic logic [6:0] model_seg(input int cyc, input logic blz);
    int s;
    logic [4*N-1:0] d;
    logic [3:0] dig;
    s   = (cyc / R) % N;
    d   = act_digits(cyc);
    dig = 4'(d >> (4 * s));
    if ((cyc % R) < G) return 7'd0;
    if (blz && s > 0 && (d >> (4 * s)) == 0) return 7'd0;
    return seg_tab[dig];
  endfunction

  function automatic logic model_dp(input int cyc);
    logic [N-1:0] p;
    p = act_dps(cyc);
    if ((cyc % R) < G) return 1'b0;
    return p[(cyc / R) % N];
  endfunction

  function automatic logic [N-1:0] model_en(input int cyc);
    logic [N-1:0] e;
    e = '0;
    if ((cyc % R) >= G) e[(cyc / R) % N] = 1'b1;
    return e;
  endfunction

  // On each edge, predict what the DUT outputs must show for cycle k+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= 0;
      exp_seg  <= '0;
      exp_dp   <= 1'b0;
      exp_en   <= '0;
      exp_fd   <= 1'b0;
      exp_scan <= '0;
      loads.delete();
    end else begin
      exp_seg  <= model_seg(k, blank_lz);
      exp_dp   <= model_dp(k);
      exp_en   <= model_en(k);
      exp_fd   <= ((k % NR) == NR - 1);
      exp_scan <= ($clog2(N))'(((k + 1) / R) % N);
      if (load) loads.push_back('{k, digits_in, dp_in});
      k <= k + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("segments", segments, exp_seg);
      check("dp_out", dp_out, exp_dp);
      check("enable_displays", enable_displays, exp_en);
      check("frame_done", frame_done, exp_fd);
      check("scan_idx", scan_idx, exp_scan);
    end
  end

  // ---------------------------------------------------------------- stimulus
  // Advance to the falling edge inside cycle m (outputs then reflect cycle m-1).
  task automatic goto(input int m);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (k != m && guard < 5000);
    check("cycle_reached", k, m);
  endtask

  task automatic do_load(input int m, input logic [4*N-1:0] d, input logic [N-1:0] p);
    goto(m);
    digits_in = d;
    dp_in     = p;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  logic [4*N-1:0] rd;

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset segments", segments, 7'd0);
    check("reset enable", enable_displays, 4'b0000);
    check("reset frame_done", frame_done, 1'b0);
    rst_n = 1'b1;

    // Scan walk, dead time, frame pulse, power-up digits all 0.
    goto(1);   check("gap enable", enable_displays, 4'b0000);
    goto(3);   check("slot0 enable", enable_displays, 4'b0001);
               check("slot0 zero", segments, 7'b0111111);
    goto(23);  check("slot1 enable", enable_displays, 4'b0010);
    goto(79);  check("no frame pulse", frame_done, 1'b0);
    goto(80);  check("frame pulse", frame_done, 1'b1);
               check("slot3 enable", enable_displays, 4'b1000);

    // Mid-frame load waits for the frame boundary.
    do_load(100, 16'h1234, 4'b0000);
    goto(105); check("held until boundary", segments, 7'b0111111);
    goto(163); check("slot0 shows 4", segments, 7'b1100110);
    goto(223); check("slot3 shows 1", segments, 7'b0000110);

    // Leading-zero blanking; dp survives blanking.
    blank_lz = 1'b1;
    do_load(240, 16'h0007, 4'b0100);
    goto(323); check("lz slot0 7", segments, 7'b0000111);
    goto(343); check("lz slot1 blank", segments, 7'd0);
    goto(363); check("lz slot2 blank", segments, 7'd0);
               check("lz slot2 dp", dp_out, 1'b1);
               check("lz slot2 enable", enable_displays, 4'b0100);
    goto(383); check("lz slot3 blank", segments, 7'd0);
    do_load(400, 16'h0000, 4'b0100);
    goto(483); check("lz all zero slot0", segments, 7'b0111111);
    goto(523); check("lz all zero slot2", segments, 7'd0);
               check("lz all zero dp", dp_out, 1'b1);

    // Last load in a frame wins; boundary-cycle load is one frame late.
    do_load(570, 16'h1111, 4'b0000);
    do_load(600, 16'h2222, 4'b0000);
    goto(643); check("last load wins s0", segments, 7'b1011011);
    goto(703); check("last load wins s3", segments, 7'b1011011);
    do_load(719, 16'h5555, 4'b0000);
    goto(723); check("boundary load deferred", segments, 7'b1011011);
    goto(803); check("boundary load shown", segments, 7'b1101101);

    // Reset during slot 2: outputs clear at once, scan restarts with 0 shown.
    goto(850);
    #2 rst_n = 1'b0;
    #1;
    check("async rst segments", segments, 7'd0);
    check("async rst enable", enable_displays, 4'b0000);
    check("async rst dp", dp_out, 1'b0);
    check("async rst scan", scan_idx, 2'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto(3);   check("restart slot0", enable_displays, 4'b0001);
               check("restart zero", segments, 7'b0111111);
    goto(43);  check("restart slot2 blank", segments, 7'd0);
               check("restart dp cleared", dp_out, 1'b0);

    // Randomized loads and blanking against the model.
    for (int c = 0; c < 2400; c++) begin
      @(negedge clk);
      load = ($urandom_range(15) == 0);
      if (load) begin
        for (int i = 0; i < N; i++)
          rd[4*i +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
        digits_in = rd;
        dp_in     = N'($urandom_range((1 << N) - 1));
      end
      if ($urandom_range(31) == 0) blank_lz = ~blank_lz;
    end
    load = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplex_display_n.md
Name: multiplex_display_n

Overview:
Parametrised successor to the 3-digit multiplexed 7-segment driver. Scans NUM_DIGITS hex digits at a programmable refresh rate and inserts dead time between digits to prevent ghosting. Double-buffers the digit values so updates land only on frame boundaries, and supports optional leading-zero blanking. Sits between keypad/BCD datapath and the board's common-select 7-segment displays.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_CNT, 50000, clk cycles per digit slot (>= GAP_CNT+2)
GAP_CNT, 500, dead-time cycles at start of each slot with all enables low (>= 0, < REFRESH_CNT-1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
digits_in  input  4*NUM_DIGITS  hex digits; digit i = bits [4i+3:4i]; digit 0 = least significant
load  input  1  1-cycle strobe: capture digits_in and dp_in into pending buffer
dp_in  input  NUM_DIGITS  decimal-point request per digit
blank_lz  input  1  leading-zero blanking enable (level, sampled every cycle)
segments  output  7  {g,f,e,d,c,b,a}, active-high, registered
dp_out  output  1  decimal point for current digit, active-high, registered
enable_displays  output  NUM_DIGITS  one-hot digit select, active-high, registered
scan_idx  output  $clog2(NUM_DIGITS)  index of current slot (internal state, unregistered copy)
frame_done  output  1  1-cycle pulse when scan wraps from NUM_DIGITS-1 to 0

Behaviour:
- Reset (async assert, sync deassert by clk): refresh counter=0, scan_idx=0, active/pending buffers=0, pending_valid=0; segments=0, dp_out=0, enable_displays=0, frame_done=0.
- Refresh counter counts 0..REFRESH_CNT-1 then wraps to 0; on wrap scan_idx increments, NUM_DIGITS-1 -> 0.
- frame_done=1 in the cycle after scan_idx wraps to 0 (registered), else 0.
- Outputs registered: value in cycle n+1 reflects counter/scan_idx/active buffer in cycle n.
- Dead time: while counter < GAP_CNT, enable_displays=0 and segments=0, dp_out=0. Otherwise enable_displays has a single 1 at bit scan_idx.
- Slot length REFRESH_CNT cycles; enable high REFRESH_CNT-GAP_CNT cycles per slot; frame = NUM_DIGITS*REFRESH_CNT cycles.
- Buffering: load=1 -> pending<=digits_in/dp_in, pending_valid<=1 (last load in a frame wins). At frame boundary (counter wrap with scan_idx==NUM_DIGITS-1): if pending_valid, active<=pending, pending_valid<=0. A load coincident with the boundary writes pending only; it is displayed from the following frame.
- Decode (hex 0-F): 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110 5=1101101 6=1111101 7=0000111 8=1111111 9=1101111 A=1110111 b=1111100 C=0111001 d=1011110 E=1111001 F=1110001.
- Leading-zero blank: if blank_lz=1, digit i>0 blanks (segments=0) when active digits i..NUM_DIGITS-1 are all 0. Digit 0 never blanks. dp_out unaffected by blanking.
- Reset mid-operation: outputs go to 0 immediately; scan restarts at slot 0; pending and active contents lost.

Optional Feature:
MUXDISP_BLINK_EN -- when defined: adds parameter BLINK_FRAMES (default 64) and input blink_mask [NUM_DIGITS-1:0] (captured into pending/active with load like digits). A blink phase bit (reset 1=on) toggles every BLINK_FRAMES frame boundaries; when phase=0, enable_displays bits for digits with active blink_mask=1 are forced 0. When not defined: no blink port or state; all digits always displayed.

Test Plan:
1. NUM_DIGITS=4, REFRESH_CNT=20, GAP_CNT=2; release reset -> enable_displays walks 0001,0010,0100,1000, each high 18 cycles separated by 2 zero cycles; frame_done every 80 cycles; before the first load all digits show 0111111.
2. load digits_in=16'h1234 mid-frame -> display unchanged until next frame boundary; afterward slot0 segments=1100110 (4), slot3=0000110 (1).
3. blank_lz=1, load 16'h0007 -> slots 3,2,1 segments=0000000, slot0=0000111; load 16'h0000 -> slot0=0111111, others blank; dp_in=4'b0100 -> dp_out=1 in slot 2 even though blanked.
4. Two loads in one frame (16'h1111 then 16'h2222) -> only 2222 appears; load asserted in the exact boundary cycle -> shown one frame later.
5. rst_n low during slot 2 -> segments/enable/dp_out 0 same cycle; after release scan restarts at slot 0 showing 0.
6. MUXDISP_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0001 -> enable_displays[0] high in frames 0-1, low in frames 2-3, repeating; other digits unaffected.
